// File: rtl/demux_seq_8.sv
// ---------------------------------------------------------------------------
// demux_seq_8
//
// Byte-to-slot sequencer feeding a 1-to-8 demultiplexer (demux_1x8_2).
// A byte accepted through a valid/ready handshake is presented one bit per
// slot: `sel` walks through the eight demux outputs and `data` carries the
// byte bit that belongs to the selected output. Each slot lasts DIV clock
// cycles so the demux outputs can be slowed down enough to watch on LEDs.
//
// Parameters
//   DIV        clock cycles per slot (0 behaves as 1)
//   LSB_FIRST  1: slot k drives sel=k, 0: slot k drives sel=7-k
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream byte available on in_byte
//   in_byte     byte to distribute over the eight slots
//   in_ready    high while idle; transfer on in_valid & in_ready
//   sel         demux select (registered)
//   data        demux data bit, always byte_q[sel] during a frame (registered)
//   slot_valid  sel/data carry a byte bit (registered)
//   busy        frame in progress, including the done cycle (registered)
//   done        one-cycle pulse after the last slot (registered)
// ---------------------------------------------------------------------------
module demux_seq_8 #(
    parameter int DIV       = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic [2:0] sel,
    output logic       data,
    output logic       slot_valid,
    output logic       busy,
    output logic       done
);

    localparam int DIV_E = (DIV < 1) ? 1 : DIV;
    localparam int CW    = (DIV_E > 1) ? $clog2(DIV_E) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_E - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [7:0]      byte_q;
    logic [2:0]      slot;
    logic [CW-1:0]   div_cnt;

    // Slot index to demux output, honouring the bit order.
    function automatic logic [2:0] slot_sel(input logic [2:0] s);
        if (LSB_FIRST != 0) begin
            return s;
        end else begin
            return 3'd7 - s;
        end
    endfunction

    assign in_ready = (state == IDLE);

    // sel and data are loaded from the same next-slot index on the same edge,
    // so the pair is always consistent at the demux inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_q     <= 8'd0;
            slot       <= 3'd0;
            div_cnt    <= '0;
            sel        <= 3'd0;
            data       <= 1'b0;
            slot_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        byte_q     <= in_byte;
                        slot       <= 3'd0;
                        div_cnt    <= '0;
                        state      <= SHIFT;
                        sel        <= slot_sel(3'd0);
                        data       <= in_byte[slot_sel(3'd0)];
                        slot_valid <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (slot == 3'd7) begin
                            state      <= DONE;
                            sel        <= 3'd0;
                            data       <= 1'b0;
                            slot_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            slot <= slot + 3'd1;
                            sel  <= slot_sel(slot + 3'd1);
                            data <= byte_q[slot_sel(slot + 3'd1)];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    sel        <= 3'd0;
                    data       <= 1'b0;
                    slot_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_seq_8.sv
// ---------------------------------------------------------------------------
// tb_demux_seq_8
//
// Bench for demux_seq_8 with three instances covering different slot
// lengths and bit orders: id 0 (DIV=1, LSB first), id 1 (DIV=3, MSB first),
// id 2 (DIV=2, LSB first). Expected outputs come from a per-cycle frame model
// written directly from the frame timing rules.
// ---------------------------------------------------------------------------
module tb_demux_seq_8;

    typedef struct packed {
        logic       rdy;
        logic [2:0] sel;
        logic       data;
        logic       sv;
        logic       busy;
        logic       done;
        logic [7:0] y;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       iv   [3];
    logic [7:0] ib   [3];
    logic       rdy  [3];
    logic [2:0] sel  [3];
    logic       dat  [3];
    logic       sv   [3];
    logic       bsy  [3];
    logic       dne  [3];

    int checks;
    int passed;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    demux_seq_8 #(.DIV(1), .LSB_FIRST(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_byte(ib[0]),
        .in_ready(rdy[0]), .sel(sel[0]), .data(dat[0]), .slot_valid(sv[0]),
        .busy(bsy[0]), .done(dne[0]));

    demux_seq_8 #(.DIV(3), .LSB_FIRST(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_byte(ib[1]),
        .in_ready(rdy[1]), .sel(sel[1]), .data(dat[1]), .slot_valid(sv[1]),
        .busy(bsy[1]), .done(dne[1]));

    demux_seq_8 #(.DIV(2), .LSB_FIRST(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_byte(ib[2]),
        .in_ready(rdy[2]), .sel(sel[2]), .data(dat[2]), .slot_valid(sv[2]),
        .busy(bsy[2]), .done(dne[2]));

    function automatic int div_of(input int id);
        case (id)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit lsb_of(input int id);
        return (id != 1);
    endfunction

    // Observed outputs, plus what an ideal 1-to-8 demux would drive.
    function automatic obs_t observe(input int id);
        obs_t o;
        o.rdy  = rdy[id];
        o.sel  = sel[id];
        o.data = dat[id];
        o.sv   = sv[id];
        o.busy = bsy[id];
        o.done = dne[id];
        o.y    = 8'd0;
        o.y[sel[id]] = dat[id];
        return o;
    endfunction

    function automatic obs_t idle_exp();
        obs_t e;
        e = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    // Expected outputs c cycles after the accept edge of byte b.
    function automatic obs_t model(input int d, input bit lsb, input logic [7:0] b, input int c);
        obs_t e;
        int   k;
        e = '0;
        if (c >= 1 && c <= 8 * d) begin
            k      = (c - 1) / d;
            e.sel  = lsb ? 3'(k) : 3'(7 - k);
            e.data = b[e.sel];
            e.sv   = 1'b1;
            e.busy = 1'b1;
            e.y[e.sel] = e.data;
        end else if (c == 8 * d + 1) begin
            e.busy = 1'b1;
            e.done = 1'b1;
        end else begin
            e.rdy = 1'b1;
        end
        return e;
    endfunction

    // Precondition: called at a negedge with the instance idle.
    // mode 0: drop in_valid after accept; mode 1: scramble inputs during the
    // frame; mode 2: keep in_valid high (back-to-back).
    // abort_c > 0 asserts reset right after sampling that cycle and returns.
    task automatic run_frame(input int id, input logic [7:0] b, input int mode,
                             input int abort_c, output int slot0_cyc);
        int   d;
        obs_t o;
        obs_t e;
        d = div_of(id);
        slot0_cyc = -1;
        iv[id] = 1'b1;
        ib[id] = b;
        checks++;
        if (rdy[id] !== 1'b1) $display("FAIL pre_accept_ready id=%0d got=%b exp=1", id, rdy[id]);
        else passed++;
        @(posedge clk);
        for (int c = 1; c <= 8 * d + 2; c++) begin
            @(negedge clk);
            o = observe(id);
            e = model(d, lsb_of(id), b, c);
            if (c == 1) slot0_cyc = cyc;
            checks++;
            if (o !== e)
                $display("FAIL frame id=%0d byte=%h c=%0d got=%h exp=%h", id, b, c, o, e);
            else passed++;
            if (abort_c != 0 && c == abort_c) begin
                #1 rst_n = 1'b0;
                iv[id] = 1'b0;
                return;
            end
            if (mode == 0) begin
                iv[id] = 1'b0;
                ib[id] = 8'($urandom);
            end else if (mode == 1) begin
                iv[id] = (c < 8 * d + 2) ? 1'($urandom) : 1'b0;
                ib[id] = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        iv[0] = 1'b1;
        ib[0] = 8'h5A;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int id = 0; id < 3; id++) begin
                checks++;
                if (observe(id) !== idle_exp())
                    $display("FAIL reset_hold id=%0d cyc=%0d got=%h exp=%h", id, i, observe(id), idle_exp());
                else passed++;
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_a5_div1();
        int s;
        run_frame(0, 8'hA5, 0, 0, s);
    endtask

    task automatic test_81_div3_msb();
        int s;
        run_frame(1, 8'h81, 0, 0, s);
    endtask

    task automatic test_stable_capture();
        int s;
        run_frame(0, 8'h3C, 1, 0, s);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (observe(0) !== idle_exp())
                $display("FAIL no_extra_frame i=%0d got=%h exp=%h", i, observe(0), idle_exp());
            else passed++;
        end
        run_frame(1, 8'($urandom), 1, 0, s);
        @(negedge clk);
        checks++;
        if (observe(1) !== idle_exp())
            $display("FAIL no_extra_frame_div3 got=%h exp=%h", observe(1), idle_exp());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        run_frame(0, 8'hFF, 2, 0, s1);
        run_frame(0, 8'h00, 0, 0, s2);
        checks++;
        if (s2 - s1 !== 10)
            $display("FAIL back_to_back_spacing got=%0d exp=10", s2 - s1);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int s;
        // Slot 4 of a DIV=2 frame spans cycles 9..10.
        run_frame(2, 8'hFF, 0, 9, s);
        #1;
        checks++;
        if (observe(2) !== idle_exp())
            $display("FAIL async_reset got=%h exp=%h", observe(2), idle_exp());
        else passed++;
        @(negedge clk);
        checks++;
        if (observe(2) !== idle_exp())
            $display("FAIL reset_held got=%h exp=%h", observe(2), idle_exp());
        else passed++;
        rst_n = 1'b1;
        run_frame(2, 8'h01, 0, 0, s);
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 6; n++) begin
            run_frame(n % 3, 8'($urandom), (n % 2 == 0) ? 0 : 1, 0, s);
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int id = 0; id < 3; id++) begin
            iv[id] = 1'b0;
            ib[id] = 8'd0;
        end
        test_reset();
        test_a5_div1();
        @(negedge clk);
        test_81_div3_msb();
        @(negedge clk);
        test_stable_capture();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_reset_mid_frame();
        @(negedge clk);
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
